// File: rtl/sys_pkg.sv
// Shared definitions for the register-file arbiter: FSM encoding and default timeout.
package sys_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam int TIMEOUT_DEFAULT = 8;

endpackage

// File: rtl/rf_arbiter_if.sv
// Requester-side and register-file-side bundles of the arbiter.
// Handshake: a requester holds REQ and its fields stable until it samples GNT=1,
// then drops REQ on that same edge; GNT, RDATA_VLD and ERR are one-cycle pulses.
interface rf_req_if #(
  parameter int DATA_WIDTH = 8,
  parameter int RF_ADDR    = 4
);
  logic                  REQ;
  logic                  WR;
  logic [RF_ADDR-1:0]    ADDR;
  logic [DATA_WIDTH-1:0] WDATA;
  logic                  GNT;
  logic [DATA_WIDTH-1:0] RDATA;
  logic                  RDATA_VLD;
  logic                  ERR;

  modport master (output REQ, WR, ADDR, WDATA, input GNT, RDATA, RDATA_VLD, ERR);
  modport slave  (input REQ, WR, ADDR, WDATA, output GNT, RDATA, RDATA_VLD, ERR);
endinterface

interface rf_bus_if #(
  parameter int DATA_WIDTH = 8,
  parameter int RF_ADDR    = 4
);
  logic                  WrEn;
  logic                  RdEn;
  logic [RF_ADDR-1:0]    Address;
  logic [DATA_WIDTH-1:0] WrData;
  logic [DATA_WIDTH-1:0] RdData;
  logic                  RdData_VLD;

  modport master (output WrEn, RdEn, Address, WrData, input RdData, RdData_VLD);
  modport slave  (input WrEn, RdEn, Address, WrData, output RdData, RdData_VLD);
endinterface

// File: rtl/rf_arbiter_rr_arb2.sv
// Two-way round-robin pick; the pointer moves away from the winner on each grant.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic       idx_o
);

  logic prio_q;

  always_comb begin
    idx_o = req_i[1];
    if (req_i == 2'b11) idx_o = prio_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       prio_q <= 1'b0;
    else if (update_i) prio_q <= ~idx_o;
  end

endmodule

// File: rtl/rf_arbiter.sv
// Arbitrates two requesters onto one register-file port; all outputs are registered
// so each strobe/pulse is visible during the FSM state that owns it.
module rf_arbiter
  import sys_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RF_ADDR    = 4,
  parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic      CLK,
  input  logic      RST,
  rf_req_if.slave   r0,
  rf_req_if.slave   r1,
  rf_bus_if.master  rf,
  output state_e    dbg_state_o
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  wr_q, wr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wren_q, wren_d, rden_q, rden_d;
  logic [RF_ADDR-1:0]    address_q, address_d;
  logic [DATA_WIDTH-1:0] wrdata_q, wrdata_d;
  logic [1:0]            gnt_q, gnt_d, rvld_q, rvld_d, err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic [1:0] req;
  logic       pick;
  logic       arb_update;

  assign req        = {r1.REQ, r0.REQ};
  assign arb_update = (state_q == ST_IDLE) && (|req);

  rr_arb2 u_rr_arb2 (
    .clk_i    (CLK),
    .rst_ni   (RST),
    .req_i    (req),
    .update_i (arb_update),
    .idx_o    (pick)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    wr_d      = wr_q;
    cnt_d     = cnt_q;
    wren_d    = 1'b0;
    rden_d    = 1'b0;
    address_d = address_q;
    wrdata_d  = wrdata_q;
    gnt_d     = 2'b00;
    rvld_d    = 2'b00;
    err_d     = 2'b00;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          owner_d   = pick;
          wr_d      = pick ? r1.WR : r0.WR;
          address_d = pick ? r1.ADDR : r0.ADDR;
          wrdata_d  = pick ? r1.WDATA : r0.WDATA;
          state_d   = ST_ISSUE;
          // Strobes are set on entry so they are seen during ISSUE itself.
          if (wr_d) begin
            wren_d      = 1'b1;
            gnt_d[pick] = 1'b1;
          end else begin
            rden_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = wr_q ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        if (rf.RdData_VLD || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
          state_d        = ST_RESP;
          gnt_d[owner_q]  = 1'b1;
          rvld_d[owner_q] = 1'b1;
          err_d[owner_q]  = ~rf.RdData_VLD;
          if (owner_q) rdata1_d = rf.RdData_VLD ? rf.RdData : '1;
          else         rdata0_d = rf.RdData_VLD ? rf.RdData : '1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      owner_q   <= 1'b0;
      wr_q      <= 1'b0;
      cnt_q     <= '0;
      wren_q    <= 1'b0;
      rden_q    <= 1'b0;
      address_q <= '0;
      wrdata_q  <= '0;
      gnt_q     <= 2'b00;
      rvld_q    <= 2'b00;
      err_q     <= 2'b00;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      wr_q      <= wr_d;
      cnt_q     <= cnt_d;
      wren_q    <= wren_d;
      rden_q    <= rden_d;
      address_q <= address_d;
      wrdata_q  <= wrdata_d;
      gnt_q     <= gnt_d;
      rvld_q    <= rvld_d;
      err_q     <= err_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign rf.WrEn      = wren_q;
  assign rf.RdEn      = rden_q;
  assign rf.Address   = address_q;
  assign rf.WrData    = wrdata_q;
  assign r0.GNT       = gnt_q[0];
  assign r1.GNT       = gnt_q[1];
  assign r0.RDATA_VLD = rvld_q[0];
  assign r1.RDATA_VLD = rvld_q[1];
  assign r0.ERR       = err_q[0];
  assign r1.ERR       = err_q[1];
  assign r0.RDATA     = rdata0_q;
  assign r1.RDATA     = rdata1_q;
  assign dbg_state_o  = state_q;

endmodule
